rx_crc_checker: RTL and testbench

Receive-side CRC-16 checker for the USB-style serial link. It sits after the receiver's bit unstuffer and consumes destuffed bits LSB-first, one per `new_bit` strobe, between `pkt_start` and `pkt_end`. At end of packet it compares the shift-register residual against the fixed USB residual and reports pass/fail. It also reports a length error when the packet is not byte-aligned or is shorter than the CRC field. It is the counterpart of the transmit-side CRC generator, which sends the complemented CRC after the payload.

---
 rtl/rx_crc_checker.sv | 172 +++++++++++++++++
 tb/tb_rx_crc_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_crc_checker.sv
// Receive-side CRC-16 checker: consumes destuffed bits LSB-first between
// pkt_start and pkt_end, then checks the residual and the packet length.
// Latency: pkt_end sampled at edge N -> results valid, crc_done high after N+1.
// Backpressure: none; a new bit may be accepted on every cycle.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   bit_in, new_bit     serial data bit and its one-cycle qualifier
//   pkt_start, pkt_end  packet delimiting pulses
//   crc_done            one-cycle pulse when the result outputs are updated
//   crc_ok, crc_err     level: last packet passed / failed
//   len_err             level: last packet length was misaligned, short or oversized
//   bit_cnt             bits accepted in the current or last packet (saturating)
module rx_crc_checker #(
  parameter int               CRC_W    = 16,
  parameter logic [CRC_W-1:0] POLY     = 16'h8005,
  parameter logic [CRC_W-1:0] INIT     = 16'hFFFF,
  parameter logic [CRC_W-1:0] RESIDUAL = 16'h800D,
  parameter int               CNT_W    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             new_bit,
  input  logic             pkt_start,
  input  logic             pkt_end,
  output logic             crc_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CRC_W-1:0] crc;
  logic             clr_pend;

  // Control strobes produced by the FSM.
  logic do_init;   // reinitialise crc / bit_cnt for a new packet
  logic do_shift;  // clock one bit into crc / bit_cnt
  logic do_eval;   // latch the pass/fail result
  logic do_clear;  // clear the result outputs
  logic do_defer;  // new packet started in DONE: clear results one edge later

  // Datapath next-state values.
  logic [CRC_W-1:0] crc_base, crc_next;
  logic [CNT_W-1:0] cnt_base, cnt_next;
  logic             fb;
  logic             len_bad;
  logic             crc_bad;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_init   = 1'b0;
    do_shift  = 1'b0;
    do_eval   = 1'b0;
    do_clear  = 1'b0;
    do_defer  = 1'b0;
    case (state)
      IDLE: begin
        // Bits and pkt_end outside a packet are dropped.
        if (pkt_start) begin
          do_init   = 1'b1;
          do_clear  = 1'b1;
          do_shift  = new_bit;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (pkt_start) begin
          // Abort: restart silently; a coincident pkt_end is ignored.
          do_init   = 1'b1;
          do_clear  = 1'b1;
          do_shift  = new_bit;
          state_nxt = RECV;
        end else begin
          do_shift = new_bit;
          do_clear = clr_pend;
          if (pkt_end) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // The last bit is already in crc/bit_cnt, so the result is taken here.
        do_eval   = 1'b1;
        state_nxt = IDLE;
        if (pkt_start) begin
          // The old result is still published with this crc_done pulse;
          // it is wiped on the following edge.
          do_init   = 1'b1;
          do_shift  = new_bit;
          do_defer  = 1'b1;
          state_nxt = RECV;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // CRC shift register and bit counter next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // A bit arriving with pkt_start is processed against INIT, not the stale crc.
    crc_base = do_init ? INIT : crc;
    cnt_base = do_init ? '0 : bit_cnt;
    fb       = bit_in ^ crc_base[CRC_W-1];
    crc_next = {crc_base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    cnt_next = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
    // A saturated count means the packet overflowed the counter.
    len_bad  = (bit_cnt[2:0] != 3'd0) || (bit_cnt < MIN_BITS) || (bit_cnt == CNT_MAX);
    crc_bad  = (crc != RESIDUAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc      <= INIT;
      bit_cnt  <= '0;
      crc_done <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      len_err  <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      crc_done <= do_eval;
      clr_pend <= do_defer;

      if (do_shift) begin
        crc     <= crc_next;
        bit_cnt <= cnt_next;
      end else if (do_init) begin
        crc     <= INIT;
        bit_cnt <= '0;
      end

      if (do_eval) begin
        len_err <= len_bad;
        crc_err <= len_bad | crc_bad;
        crc_ok  <= ~(len_bad | crc_bad);
      end else if (do_clear) begin
        len_err <= 1'b0;
        crc_err <= 1'b0;
        crc_ok  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_crc_checker.sv
// Bench for rx_crc_checker: a driver issues packets and queues the expected
// result; a monitor pops and compares on every crc_done pulse.
module tb_rx_crc_checker;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        new_bit;
  logic        pkt_start;
  logic        pkt_end;
  logic        crc_done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic [13:0] bit_cnt;

  rx_crc_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .new_bit   (new_bit),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .crc_done  (crc_done),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit ok;
    bit err;
    bit len;
    int cnt;   // -1: bit_cnt already belongs to the next packet
    int cyc;   // cycle number at which crc_done must be seen
  } exp_t;

  exp_t exp_q[$];
  bit   stim_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: the register after n bits equals
  // (INIT * x^n + D(x) * x^16) mod P, with D's first bit as highest term.
  function automatic logic [15:0] ref_rem(input bit q[$]);
    bit          m [0:1023];
    logic [15:0] init_v;
    logic [15:0] r;
    int          n;
    n      = q.size();
    init_v = 16'hFFFF;
    for (int k = 0; k < 1024; k++) m[k] = 1'b0;
    for (int k = 0; k < 16; k++) m[n + k] ^= init_v[k];
    for (int i = 0; i < n; i++) m[n + 15 - i] ^= q[i];
    for (int e = n + 15; e >= 16; e--) begin
      if (m[e]) begin
        m[e]      ^= 1'b1;
        m[e - 1]  ^= 1'b1;
        m[e - 14] ^= 1'b1;
        m[e - 16] ^= 1'b1;
      end
    end
    for (int k = 0; k < 16; k++) r[k] = m[k];
    return r;
  endfunction

  // Transmit side: data followed by the complemented CRC, high bit first.
  task automatic build_good(input int ndata, input bit all_ones);
    logic [15:0] r;
    stim_q.delete();
    for (int i = 0; i < ndata; i++) stim_q.push_back(all_ones ? 1'b1 : 1'($urandom_range(0, 1)));
    r = ref_rem(stim_q);
    for (int k = 15; k >= 0; k--) stim_q.push_back(~r[k]);
  endtask

  task automatic build_const(input int n, input bit v);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  task automatic build_rand(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic push_exp(input bit cnt_dc);
    exp_t e;
    int   n;
    int   cnt;
    n     = stim_q.size();
    cnt   = (n > 16383) ? 16383 : n;
    e.len = (cnt % 8 != 0) || (cnt < 16) || (cnt == 16383);
    e.err = e.len || (ref_rem(stim_q) != 16'h800D);
    e.ok  = !e.err;
    e.cnt = cnt_dc ? -1 : cnt;
    e.cyc = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pkt_start = 1'b0;
    pkt_end   = 1'b0;
    new_bit   = 1'b0;
    repeat (n) tick();
  endtask

  // Sends stim_q as one packet.
  //   gap          idle cycles before each strobed bit
  //   end_on_last  pkt_end coincides with the last new_bit
  //   fws          first bit is strobed in the pkt_start cycle
  //   abort        no pkt_end at all (packet is cut off)
  //   eas          pkt_end also high in the pkt_start cycle
  //   cnt_dc       next packet follows back-to-back, so bit_cnt is not compared
  task automatic run_pkt(input int gap, input bit end_on_last, input bit fws,
                         input bit abort, input bit eas, input bit cnt_dc);
    int n;
    int i0;
    bit ended;
    n     = stim_q.size();
    i0    = 0;
    ended = 1'b0;
    pkt_start = 1'b1;
    pkt_end   = eas;
    new_bit   = 1'b0;
    bit_in    = 1'b0;
    if (fws && n > 0) begin
      new_bit = 1'b1;
      bit_in  = stim_q[0];
      i0      = 1;
    end
    tick();
    pkt_start = 1'b0;
    pkt_end   = 1'b0;
    new_bit   = 1'b0;
    for (int i = i0; i < n; i++) begin
      repeat (gap) tick();
      new_bit = 1'b1;
      bit_in  = stim_q[i];
      if (end_on_last && !abort && i == n - 1) begin
        pkt_end = 1'b1;
        ended   = 1'b1;
        push_exp(cnt_dc);
      end
      tick();
      new_bit = 1'b0;
      pkt_end = 1'b0;
    end
    if (!abort && !ended) begin
      pkt_end = 1'b1;
      push_exp(cnt_dc);
      tick();
      pkt_end = 1'b0;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_crc_ok"},   crc_ok,   0);
    check({tag, "_crc_err"},  crc_err,  0);
    check({tag, "_len_err"},  len_err,  0);
    check({tag, "_crc_done"}, crc_done, 0);
    check({tag, "_bit_cnt"},  bit_cnt,  0);
    check({tag, "_crc_reg"},  dut.crc,  16'hFFFF);
  endtask

  // Monitor: compares each crc_done pulse against the scoreboard.
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_done) check("done_width", crc_done, 0);
      if (crc_done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got crc_done=1 expected no pulse (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("done_latency", cyc,     e.cyc);
          check("crc_ok",       crc_ok,  e.ok);
          check("crc_err",      crc_err, e.err);
          check("len_err",      len_err, e.len);
          if (e.cnt >= 0) check("bit_cnt", bit_cnt, e.cnt);
        end
      end
    end
    prev_done = rst ? 1'b0 : crc_done;
  end

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b0;
    new_bit   = 1'b0;
    pkt_start = 1'b0;
    pkt_end   = 1'b0;
    repeat (2) tick();
    check_cleared("reset_hold");
    rst = 1'b0;
    tick();
    check_cleared("reset_release");

    // Empty payload: complemented CRC of nothing is 16 zeros.
    build_const(16, 1'b0); run_pkt(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
    // Corrupted CRC.
    build_const(16, 1'b1); run_pkt(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
    // Round trip, misaligned (38 bits) then aligned (40 bits).
    build_good(22, 1'b1); run_pkt(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
    build_good(24, 1'b1); run_pkt(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
    // Gapped strobes, pkt_end on the last bit.
    build_const(16, 1'b0); run_pkt(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
    // Short and misaligned packets.
    build_const(8, 1'b0); run_pkt(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
    build_rand(17);       run_pkt(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(4);
    // Abort after 5 bits; restart also carries a pkt_end that must be ignored.
    build_rand(5);         run_pkt(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    build_const(16, 1'b0); run_pkt(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); idle(4);
    // First bit together with pkt_start.
    build_good(8, 1'b0); run_pkt(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(4);
    // Back-to-back: second pkt_start lands in DONE.
    build_const(16, 1'b0); run_pkt(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    build_good(16, 1'b0);  run_pkt(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); idle(4);

    // Reset mid-packet after 10 bits.
    build_rand(10); run_pkt(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_reset_bit_cnt", bit_cnt, 10);
    rst = 1'b1;
    #1;
    check_cleared("mid_reset");
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_cleared("post_reset");

    // Randomised packets.
    for (int t = 0; t < 40; t++) begin
      int mode;
      bit b2b;
      mode = $urandom_range(0, 3);
      case (mode)
        0, 1:    build_good(8 * $urandom_range(0, 8), 1'b0);
        2:       build_good($urandom_range(1, 40), 1'b0);
        default: build_rand($urandom_range(1, 60));
      endcase
      b2b = ($urandom_range(0, 4) == 0) && (t != 39);
      run_pkt($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b0, 1'b0, b2b);
      if (!b2b) idle($urandom_range(1, 4));
    end

    idle(6);
    check("all_done_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
